// File: rtl/fib_seq_pkg.sv
// Shared types and constants for the Fibonacci-style sequence generator.
// Holds the controller state encoding, the mode codes and the Lucas seeds.
package fib_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [1:0] MODE_FIB   = 2'b00;
    localparam logic [1:0] MODE_LUCAS = 2'b01;
    localparam logic [1:0] MODE_USER  = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    localparam int unsigned LUCAS_SEED_A = 2;
    localparam int unsigned LUCAS_SEED_B = 1;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Request/stream bundle for fib_seq_gen. The master side issues requests
// and consumes terms; the slave side is the generator.
interface fib_seq_gen_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 8
) ();

    logic               start;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   seed_a;
    logic [WIDTH-1:0]   seed_b;
    logic [COUNT_W-1:0] num_terms;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic               overflow;

    modport master (
        output start, mode, seed_a, seed_b, num_terms, out_ready,
        input  out_data, out_valid, busy, done, overflow
    );

    modport slave (
        input  start, mode, seed_a, seed_b, num_terms, out_ready,
        output out_data, out_valid, busy, done, overflow
    );

endinterface

// File: rtl/fib_term_reg.sv
// Pair of term registers A/B: load seeds, advance (A<=B, B<=A+B) or hold.
// carry reports the carry-out of the current A+B.
module fib_term_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             carry
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum = {1'b0, a_q} + {1'b0, b_q};
        a_d = a_q;
        b_d = b_q;
        if (load) begin
            a_d = seed_a;
            b_d = seed_b;
        end else if (advance) begin
            a_d = b_q;
            b_d = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign carry = sum[WIDTH];

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci/Lucas/user-seeded sequence generator with a valid/ready output
// stream, term counter and sticky overflow flag.
module fib_seq_gen
    import fib_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 8
) (
    input  logic          clock,
    input  logic          reset,
    fib_seq_gen_if.slave  bus
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   first_seed, second_seed;
    logic [WIDTH-1:0]   term_a, term_b;
    logic               carry;
    logic               load;
    logic               handshake;
    logic               last_term;

    always_comb begin
        case (bus.mode)
            MODE_LUCAS: begin
                first_seed  = WIDTH'(LUCAS_SEED_A);
                second_seed = WIDTH'(LUCAS_SEED_B);
            end
            MODE_USER: begin
                first_seed  = bus.seed_a;
                second_seed = bus.seed_b;
            end
            default: begin
                first_seed  = '0;
                second_seed = WIDTH'(1);
            end
        endcase
    end

    assign handshake = (state_q == ST_RUN) && bus.out_ready;
    assign last_term = (cnt_q == num_q - COUNT_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    num_d   = bus.num_terms;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.num_terms != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    cnt_d = cnt_q + COUNT_W'(1);
                    if (carry) ovf_d = 1'b1;
                    if (last_term) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
        end
    end

    fib_term_reg #(.WIDTH(WIDTH)) u_terms (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .advance (handshake),
        .seed_a  (first_seed),
        .seed_b  (second_seed),
        .a       (term_a),
        .b       (term_b),
        .carry   (carry)
    );

    // B is only needed internally for the next sum; out_data is gated to 0 when idle.
    logic unused_b;
    assign unused_b = ^term_b;

    assign bus.out_valid = (state_q == ST_RUN);
    assign bus.out_data  = (state_q == ST_RUN) ? term_a : '0;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen: directed scenarios plus randomized
// sequences compared against a term-list model of the sequence rules.
module tb_fib_seq_gen;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned COUNT_W = 8;

    logic clock = 1'b0;
    logic reset;
    int unsigned tests = 0;
    int unsigned fails = 0;

    fib_seq_gen_if #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) bus ();

    fib_seq_gen #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_data"},  32'(bus.out_data), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
    endtask

    // stall_kind: 0 always ready, 1 three-cycle stall at stall_idx, 2 random stalls.
    task automatic run_seq(input logic [1:0] mode, input logic [7:0] sa, input logic [7:0] sb,
                           input int unsigned n, input int unsigned stall_kind,
                           input int unsigned stall_idx, input int abort_idx, input bit poke_start);
        int unsigned t[64];
        int unsigned idx;
        int unsigned stalls;
        bit ov;
        bit rdy;
        case (mode)
            2'b01:   begin t[0] = 2;  t[1] = 1;  end
            2'b10:   begin t[0] = sa; t[1] = sb; end
            default: begin t[0] = 0;  t[1] = 1;  end
        endcase
        for (int unsigned k = 2; k < n + 2; k++) t[k] = (t[k-1] + t[k-2]) % 256;

        bus.start     = 1'b1;
        bus.mode      = mode;
        bus.seed_a    = sa;
        bus.seed_b    = sb;
        bus.num_terms = COUNT_W'(n);
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.mode      = 2'($urandom);
        bus.seed_a    = 8'($urandom);
        bus.seed_b    = 8'($urandom);
        bus.num_terms = 8'($urandom);
        ov = 1'b0;

        if (n == 0) begin
            check("zero_valid", 32'(bus.out_valid), 0);
            check("zero_data",  32'(bus.out_data), 0);
            check("zero_busy",  32'(bus.busy), 0);
            check("zero_done",  32'(bus.done), 1);
            tick();
            check_idle("zero_after");
            return;
        end

        idx = 0;
        stalls = 0;
        while (idx < n) begin
            if (abort_idx == int'(idx)) begin
                reset = 1'b1;
                bus.start = 1'b1;
                tick();
                reset = 1'b0;
                bus.start = 1'b0;
                check_idle("abort");
                check("abort_ovf", 32'(bus.overflow), 0);
                tick();
                check_idle("abort_after");
                return;
            end
            case (stall_kind)
                0:       rdy = 1'b1;
                1:       rdy = !(idx == stall_idx && stalls < 3);
                default: rdy = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (poke_start) bus.start = 1'($urandom_range(0, 1));
            check("run_valid", 32'(bus.out_valid), 1);
            check("run_data",  32'(bus.out_data), t[idx]);
            check("run_busy",  32'(bus.busy), 1);
            check("run_done",  32'(bus.done), 0);
            check("run_ovf",   32'(bus.overflow), 32'(ov));
            tick();
            if (rdy) begin
                if (t[idx] + t[idx+1] > 255) ov = 1'b1;
                idx++;
                stalls = 0;
            end else begin
                stalls++;
            end
        end

        bus.start = poke_start;
        check("end_done",  32'(bus.done), 1);
        check("end_valid", 32'(bus.out_valid), 0);
        check("end_data",  32'(bus.out_data), 0);
        check("end_busy",  32'(bus.busy), 0);
        check("end_ovf",   32'(bus.overflow), 32'(ov));
        tick();
        bus.start = 1'b0;
        check_idle("post");
        check("post_ovf", 32'(bus.overflow), 32'(ov));
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.mode      = 2'b00;
        bus.seed_a    = '0;
        bus.seed_b    = '0;
        bus.num_terms = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check("reset_ovf", 32'(bus.overflow), 0);
        reset = 1'b0;
        tick();

        run_seq(2'b00, 8'd0, 8'd0, 10, 0, 0, -1, 1'b0);
        run_seq(2'b01, 8'd0, 8'd0, 5,  0, 0, -1, 1'b0);
        run_seq(2'b10, 8'd5, 8'd5, 4,  0, 0, -1, 1'b0);
        run_seq(2'b00, 8'd0, 8'd0, 6,  1, 3, -1, 1'b0);
        run_seq(2'b00, 8'd0, 8'd0, 15, 0, 0, -1, 1'b0);
        run_seq(2'b00, 8'd0, 8'd0, 3,  0, 0, -1, 1'b0);
        run_seq(2'b00, 8'd0, 8'd0, 0,  0, 0, -1, 1'b0);
        run_seq(2'b00, 8'd0, 8'd0, 8,  0, 0, -1, 1'b1);
        run_seq(2'b00, 8'd0, 8'd0, 10, 0, 0, 6,  1'b0);
        run_seq(2'b00, 8'd0, 8'd0, 5,  0, 0, -1, 1'b0);
        run_seq(2'b11, 8'd9, 8'd9, 7,  0, 0, -1, 1'b0);
        run_seq(2'b10, 8'd200, 8'd100, 6, 2, 0, -1, 1'b1);

        for (int r = 0; r < 25; r++) begin
            run_seq(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    $urandom_range(0, 20), 2, 0, -1, 1'($urandom_range(0, 1)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fib_seq_gen.md
FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 Parameter WIDTH, default 8: bit width of terms and seeds.
REQ-002 Parameter COUNT_W, default 8: bit width of term counter and num_terms.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 start  input  1  request a new sequence; sampled only in IDLE.
REQ-006 mode  input  2  seed select: 00 Fibonacci (0,1); 01 Lucas (2,1); 10 user (seed_a,seed_b); 11 reserved, treated as 00.
REQ-007 seed_a, seed_b  input  WIDTH each  user seeds, first and second term.
REQ-008 num_terms  input  COUNT_W  number of terms to emit.
REQ-009 out_data  output  WIDTH  current term.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 busy  output  1  high in LOAD and RUN.
REQ-013 done  output  1  one-cycle pulse at end of sequence.
REQ-014 overflow  output  1  sticky flag: a term was computed with carry-out.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
- IDLE -> RUN on start=1 with num_terms!=0.
- IDLE -> DONE on start=1 with num_terms=0.
- RUN -> DONE on the handshake of the last term.
- DONE -> IDLE unconditionally after one cycle.
REQ-016 On start in IDLE, the block SHALL latch num_terms, load A=first seed and B=second seed for the selected mode, clear term_cnt, and clear overflow.
REQ-017 out_valid SHALL be high in the first cycle after start is accepted; start-to-first-valid latency is 1 cycle.
REQ-018 In RUN: out_valid=1 and out_data=A; a handshake is out_valid and out_ready both high at a rising edge.
REQ-019 On each handshake: A<=B; B<=(A+B) truncated to WIDTH bits; term_cnt<=term_cnt+1.
REQ-020 If the carry-out of A+B is 1 at a handshake, overflow SHALL set and stay set until the next accepted start or reset; wrapped values SHALL still be emitted.
REQ-021 While out_valid=1 and out_ready=0, out_data, A, B and term_cnt SHALL hold unchanged.
REQ-022 The handshake with term_cnt=num_terms-1 ends the sequence; exactly num_terms terms SHALL be emitted.
REQ-023 done SHALL be 1 only in DONE, for exactly one cycle; out_valid SHALL be 0 in IDLE and DONE.
REQ-024 start while busy or in DONE SHALL be ignored; input changes after start is accepted SHALL have no effect.
REQ-025 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, A=0, B=0, term_cnt=0, overflow=0, regardless of state.
REQ-027 After the reset edge, out_valid=0, busy=0, done=0 and out_data=0.
REQ-028 Reset mid-sequence SHALL abort the sequence with no done pulse.
REQ-029 Reset has priority over start.

Structure
REQ-030 Package fib_seq_pkg SHALL hold the state enum, the mode codes, and the Lucas seed constants (2,1).
REQ-031 The A/B term registers SHALL be one sub-module, fib_term_reg (parametrised WIDTH, load/advance/hold, carry-out), instantiated once; the FSM and counter SHALL stay in fib_seq_gen.

Verification
REQ-032 Fibonacci, WIDTH=8, num_terms=10, out_ready=1 -> out_data 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; done one cycle later; overflow=0.
REQ-033 Lucas, num_terms=5 -> 2,1,3,4,7; then mode=10, seed_a=5, seed_b=5, num_terms=4 -> 5,5,10,15.
REQ-034 Fibonacci, num_terms=6, out_ready low for 3 cycles while out_data=2 -> out_data held at 2 and out_valid held high; sequence resumes 3,5 with no term lost or repeated.
REQ-035 Fibonacci, WIDTH=8, num_terms=15 -> last terms 144,233,121; overflow rises the cycle after 144 is accepted; overflow cleared by the next start.
REQ-036 num_terms=0 start -> no out_valid, done pulse 1 cycle after start; start during RUN -> ignored, sequence unchanged.
REQ-037 reset asserted while out_data=8 -> next cycle IDLE with all outputs 0 and no done pulse; a following start restarts from 0.
